// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - memory bus bundle shared by the cmu ports and the memory side
// Purpose: one bus (chip select, write enable, address, write data, read data, ack).
// Ports (signals):
//   cs, we, addr, wdata : driven by the master (requester / arbiter toward memory)
//   rdata, ack          : driven by the slave  (arbiter toward requester / memory)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output cs, we, addr, wdata, input rdata, ack);
  modport slave  (input cs, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port burst arbiter for the shared external memory bus
// Purpose: shares one memory bus between the D-cache cmu (p0) and the I-cache cmu (p1).
//   A grant lasts as long as the owner holds cs, is never pre-empted, and every
//   ownership change passes through a turnaround state so each cmu sees a clean
//   0->1 ack edge.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   p0, p1  : requester buses (slave side of the arbiter)
//   mem     : memory bus (master side of the arbiter)
//   grant_o : one-hot current owner {p1,p0}, 00 when no owner
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TURN_MIN = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        p0,
  mem_arbiter_if.slave        p1,
  mem_arbiter_if.master       mem,
  output logic [1:0]          grant_o
);

  localparam int CW = (TURN_MIN < 1) ? 1 : $clog2(TURN_MIN + 1);
  localparam logic [CW-1:0]     TURN_LIM  = CW'(TURN_MIN);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  typedef enum logic [1:0] {S_IDLE, S_G0, S_G1, S_TURN} state_t;

  state_t        state;
  logic          rr;       // last owner; the other port wins a tie
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          turn_done;
  logic          pick0;
  logic          pick1;

  assign pick0 = p0.cs & (~p1.cs | rr);
  assign pick1 = p1.cs & (~p0.cs | ~rr);

  // The current turnaround cycle counts toward TURN_MIN, so with TURN_MIN=1
  // the bus is idle for exactly one cycle between owners.
  assign cnt_next  = (cnt >= TURN_LIM) ? TURN_LIM : cnt + CW'(1);
  assign turn_done = (cnt_next >= TURN_LIM) & ~mem.ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rr      <= 1'b1;
      cnt     <= '0;
      grant_o <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick0) begin
            state   <= S_G0;
            grant_o <= 2'b01;
          end else if (pick1) begin
            state   <= S_G1;
            grant_o <= 2'b10;
          end
        end
        S_G0: begin
          if (!p0.cs) begin
            state   <= S_TURN;
            rr      <= 1'b0;
            cnt     <= '0;
            grant_o <= 2'b00;
          end
        end
        S_G1: begin
          if (!p1.cs) begin
            state   <= S_TURN;
            rr      <= 1'b1;
            cnt     <= '0;
            grant_o <= 2'b00;
          end
        end
        S_TURN: begin
          cnt <= cnt_next;
          if (turn_done) begin
            if (pick0) begin
              state   <= S_G0;
              grant_o <= 2'b01;
            end else if (pick1) begin
              state   <= S_G1;
              grant_o <= 2'b10;
            end else begin
              state   <= S_IDLE;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  // Bus mux follows the registered state; reset forces S_IDLE asynchronously,
  // so every output drops to 0 the moment rst falls.
  always_comb begin
    mem.cs    = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = ADDR_ZERO;
    mem.wdata = DATA_ZERO;
    p0.ack    = 1'b0;
    p0.rdata  = DATA_ZERO;
    p1.ack    = 1'b0;
    p1.rdata  = DATA_ZERO;
    case (state)
      S_G0: begin
        mem.cs    = p0.cs;
        mem.we    = p0.we;
        mem.addr  = p0.addr;
        mem.wdata = p0.wdata;
        p0.ack    = mem.ack;
        p0.rdata  = mem.rdata;
      end
      S_G1: begin
        mem.cs    = p1.cs;
        mem.we    = p1.we;
        mem.addr  = p1.addr;
        mem.wdata = p1.wdata;
        p1.ack    = mem.ack;
        p1.rdata  = mem.rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single external memory bus (cs/we/addr/data/ack) between the D-cache cmu (port 0) and the I-cache cmu (port 1) of the pipelined CPU.
- Grants whole bursts: a grant is held while the owner keeps cs high (line write-back plus fill) and is never pre-empted.
- Inserts a turnaround state between owners so each cmu's ack rising-edge detector sees a clean 0→1 edge.
- Sits between the two cmu instances and the memory/bus wrapper.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TURN_MIN, 1, minimum cycles with mem_cs_o=0 between two grants (≥1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- p0_cs_i  input  1  port 0 (D-cache) request/chip select, held for whole burst
- p0_we_i  input  1  port 0 write enable
- p0_addr_i  input  ADDR_W  port 0 address
- p0_data_i  input  DATA_W  port 0 write data
- p0_data_o  output  DATA_W  read data to port 0
- p0_ack_o  output  1  ack to port 0
- p1_cs_i, p1_we_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: same as port 0, for port 1 (I-cache)
- mem_cs_o  output  1  memory chip select
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_W  memory address
- mem_data_o  output  DATA_W  memory write data
- mem_data_i  input  DATA_W  memory read data
- mem_ack_i  input  1  memory ack (level; may stay high several cycles)
- grant_o  output  2  one-hot current owner ({p1,p0}); 00 when no owner

Behaviour:
- State register: S_IDLE, S_G0, S_G1, S_TURN. Also holds a last-owner bit (rr) and a turnaround counter, width clog2(TURN_MIN+1).
- Reset (rst=0, asynchronous): state=S_IDLE, rr=1 (port 0 wins the first tie), counter=0. All outputs 0 while rst=0: grant_o, mem_cs_o, mem_we_o, mem_addr_o, mem_data_o, p*_ack_o, p*_data_o.
- S_IDLE:
  - Only one cs high → go to that port's grant state.
  - Both high → grant the port that is not rr.
  - Neither high → stay.
  - Decision is registered: a request first seen high at edge N drives mem_cs_o=1 in the cycle after edge N (1-cycle grant latency).
- S_Gk:
  - Memory outputs = port k's cs/we/addr/data, combinationally muxed.
  - pk_ack_o = mem_ack_i. The other port's ack is forced 0.
  - mem_data_i is routed to pk_data_o only. The other data_o is 0.
  - pk_cs_i=0 at an edge → rr=k, counter=0, go to S_TURN. The other port's request is ignored, however long it has been waiting.
- S_TURN:
  - All mem_* outputs 0, both acks 0, grant_o=00.
  - counter increments each cycle, saturating at TURN_MIN.
  - Exit requires counter≥TURN_MIN and mem_ack_i=0. A lingering ack extends S_TURN until it drops.
  - On exit, arbitration follows the S_IDLE rules in the same edge (direct S_TURN→S_Gx allowed). With no request, go to S_IDLE.
- Simultaneous events:
  - Owner drops cs while the other port requests → always passes through S_TURN first; never owner-to-owner in one edge.
  - Owner drops cs and re-raises it in S_TURN while the other port also requests → the other port wins (round-robin).
- mem_ack_i while in S_IDLE is ignored (no ack forwarded).
- Reset mid-burst: outputs clear immediately (asynchronous). After release, arbitration restarts from S_IDLE with rr=1.
- No X on outputs: non-granted data/ack are driven 0.

Test Plan:
- Reset: hold rst=0 with both cs=1 → all outputs 0 and grant_o=00. Release rst → grant_o=01 in the cycle after the next edge; mem_addr_o=p0_addr_i.
- Single burst: p1 requests addr 0x0000_0040, memory acks 4 beats with data 0xA0..0xA3 → p1_ack_o mirrors mem_ack_i, p1_data_o=0xA0..0xA3, p0_ack_o stays 0.
- Contention/round-robin: both cs=1 from reset → p0 granted. p0 drops cs → S_TURN for 1 cycle → p1 granted. Both re-request after p1 drops → p0 granted.
- Lingering ack: owner drops cs while mem_ack_i stays high 3 more cycles → mem_cs_o stays 0 for those 3 cycles; next grant only after ack=0.
- Long burst: p0 holds cs for 20 cycles (back + fill, 8 acks) while p1 waits → no pre-emption; p1 granted ≥TURN_MIN+1 cycles after p0 drops.
- Async reset mid-burst: rst=0 asserted between edges during S_G1 → mem_cs_o=0 and p1_ack_o=0 immediately. After release with p1_cs=1, p1 is re-granted.
